// File: rtl/scie_fir_mac_seq.sv
// Multi-channel FIR accelerator on the SCIE custom-instruction interface.
// One shared multiply-accumulate walks the taps of one channel per PUSH.
//
// state  | meaning
// IDLE   | accepting commands, io_ready high
// MAC    | accumulating coef*x one tap per cycle
// WB     | shift/saturate accumulator, write channel result
module scie_fir_mac_seq #(
  parameter int XLEN     = 32,
  parameter int TAPS     = 8,
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 2*XLEN+5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_valid,
  output logic            io_ready,
  input  logic [31:0]     io_insn,
  input  logic [XLEN-1:0] io_rs1,
  input  logic [XLEN-1:0] io_rs2,
  output logic [XLEN-1:0] io_rd,
  output logic            io_rd_valid
);

  localparam int TAP_W = $clog2(TAPS);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SH_W  = $clog2(ACC_W);

  localparam logic [6:0] OP_SETCOEF = 7'h0B;
  localparam logic [6:0] OP_PUSH    = 7'h2B;
  localparam logic [6:0] OP_READ    = 7'h5B;
  localparam logic [6:0] OP_CONFIG  = 7'h7B;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-XLEN+1){1'b0}}, {(XLEN-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-XLEN+1){1'b1}}, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB} state_t;

  state_t state, state_nxt;

  logic signed [XLEN-1:0] coef   [CHANNELS][TAPS];
  logic signed [XLEN-1:0] xline  [CHANNELS][TAPS];
  logic        [XLEN-1:0] result [CHANNELS];
  logic        [SH_W-1:0] shift_r [CHANNELS];
  logic                   sat_r  [CHANNELS];

  logic signed [ACC_W-1:0] acc;
  logic [TAP_W-1:0]        k;
  logic [CH_W-1:0]         cur_ch;

  logic [6:0]      opcode;
  logic [2:0]      ch_raw;
  logic [CH_W-1:0] ch_idx;
  logic            ch_ok;
  logic            accept;
  logic            do_setcoef, do_push, do_read, do_config;
  logic [SH_W-1:0] cfg_shift;

  logic signed [2*XLEN-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  shifted;
  logic        [XLEN-1:0]   wb_val;

  assign opcode = io_insn[6:0];
  assign ch_raw = io_insn[14:12];
  assign ch_idx = ch_raw[CH_W-1:0];
  assign ch_ok  = (int'(ch_raw) < CHANNELS);
  assign accept = io_valid && io_ready;

  assign do_setcoef = accept && ch_ok && (opcode == OP_SETCOEF) && (io_rs2 < XLEN'(TAPS));
  assign do_push    = accept && ch_ok && (opcode == OP_PUSH);
  assign do_read    = accept && ch_ok && (opcode == OP_READ);
  assign do_config  = accept && ch_ok && (opcode == OP_CONFIG);

  assign cfg_shift = (int'(io_rs1[5:0]) > ACC_W-1) ? SH_W'(ACC_W-1) : SH_W'(io_rs1[5:0]);

  assign prod     = coef[cur_ch][k] * xline[cur_ch][k];
  assign prod_ext = {{(ACC_W-2*XLEN){prod[2*XLEN-1]}}, prod};
  assign shifted  = acc >>> shift_r[cur_ch];

  always_comb begin
    wb_val = shifted[XLEN-1:0];
    if (sat_r[cur_ch]) begin
      if (shifted > SAT_MAX)      wb_val = SAT_MAX[XLEN-1:0];
      else if (shifted < SAT_MIN) wb_val = SAT_MIN[XLEN-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    io_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        io_ready = 1'b1;
        if (do_push) state_nxt = S_MAC;
      end
      S_MAC:   if (k == TAP_W'(TAPS-1)) state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int t = 0; t < TAPS; t++) begin
          coef[c][t]  <= '0;
          xline[c][t] <= '0;
        end
        result[c]  <= '0;
        shift_r[c] <= '0;
        sat_r[c]   <= 1'b0;
      end
      acc         <= '0;
      k           <= '0;
      cur_ch      <= '0;
      io_rd       <= '0;
      io_rd_valid <= 1'b0;
    end else begin
      io_rd_valid <= do_read;
      if (do_read) io_rd <= result[ch_idx];

      if (do_setcoef) coef[ch_idx][io_rs2[TAP_W-1:0]] <= io_rs1;

      if (do_push) begin
        xline[ch_idx][0] <= io_rs1;
        for (int t = 1; t < TAPS; t++) xline[ch_idx][t] <= xline[ch_idx][t-1];
        acc    <= '0;
        k      <= '0;
        cur_ch <= ch_idx;
      end

      if (do_config) begin
        shift_r[ch_idx] <= cfg_shift;
        sat_r[ch_idx]   <= io_rs1[8];
        if (io_rs1[9]) begin
          for (int t = 0; t < TAPS; t++) xline[ch_idx][t] <= '0;
          result[ch_idx] <= '0;
        end
      end

      if (state == S_MAC) begin
        acc <= acc + prod_ext;
        k   <= k + 1'b1;
      end

      if (state == S_WB) result[cur_ch] <= wb_val;
    end
  end

endmodule

// File: tb/tb_scie_fir_mac_seq.sv
// Self-checking bench for scie_fir_mac_seq: directed scenarios plus random
// command streams compared against a plain-arithmetic filter model.
module tb_scie_fir_mac_seq;

  localparam int XLEN     = 32;
  localparam int TAPS     = 8;
  localparam int CHANNELS = 2;
  localparam int ACC_W    = 2*XLEN+5;

  localparam logic [6:0] OP_SETCOEF = 7'h0B;
  localparam logic [6:0] OP_PUSH    = 7'h2B;
  localparam logic [6:0] OP_READ    = 7'h5B;
  localparam logic [6:0] OP_CONFIG  = 7'h7B;
  localparam logic [6:0] OP_UNK     = 7'h13;

  logic            clock, reset, io_valid, io_ready, io_rd_valid;
  logic [31:0]     io_insn;
  logic [XLEN-1:0] io_rs1, io_rs2, io_rd;

  int compared   = 0;
  int mismatched = 0;

  scie_fir_mac_seq #(.XLEN(XLEN), .TAPS(TAPS), .CHANNELS(CHANNELS), .ACC_W(ACC_W)) dut (
    .clock(clock), .reset(reset), .io_valid(io_valid), .io_ready(io_ready),
    .io_insn(io_insn), .io_rs1(io_rs1), .io_rs2(io_rs2),
    .io_rd(io_rd), .io_rd_valid(io_rd_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model state
  logic signed [XLEN-1:0] cm [CHANNELS][TAPS];
  logic signed [XLEN-1:0] xm [CHANNELS][TAPS];
  logic        [XLEN-1:0] rm [CHANNELS];
  int                     shm [CHANNELS];
  bit                     satm [CHANNELS];
  logic        [XLEN-1:0] last_rd;

  function automatic void model_clear();
    for (int c = 0; c < CHANNELS; c++) begin
      for (int t = 0; t < TAPS; t++) begin
        cm[c][t] = '0;
        xm[c][t] = '0;
      end
      rm[c] = '0; shm[c] = 0; satm[c] = 1'b0;
    end
    last_rd = '0;
  endfunction

  function automatic void model_cmd(input logic [6:0] op, input int ch,
                                    input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2);
    logic signed [ACC_W-1:0] sum, t, hi, lo;
    if (ch >= CHANNELS) return;
    hi = 64'sh7FFFFFFF;
    lo = -64'sh80000000;
    case (op)
      OP_SETCOEF: if (rs2 < TAPS) cm[ch][rs2] = rs1;
      OP_PUSH: begin
        for (int i = TAPS-1; i > 0; i--) xm[ch][i] = xm[ch][i-1];
        xm[ch][0] = rs1;
        sum = '0;
        for (int i = 0; i < TAPS; i++) sum = sum + cm[ch][i] * xm[ch][i];
        t = sum >>> shm[ch];
        if (satm[ch] && t > hi) t = hi;
        if (satm[ch] && t < lo) t = lo;
        rm[ch] = t[XLEN-1:0];
      end
      OP_READ: last_rd = rm[ch];
      OP_CONFIG: begin
        shm[ch]  = (int'(rs1[5:0]) > ACC_W-1) ? ACC_W-1 : int'(rs1[5:0]);
        satm[ch] = rs1[8];
        if (rs1[9]) begin
          for (int i = 0; i < TAPS; i++) xm[ch][i] = '0;
          rm[ch] = '0;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic send(input logic [6:0] op, input logic [2:0] ch,
                      input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2);
    logic [31:0] r;
    bit ok;
    ok = 1'b0;
    r  = $urandom;
    @(negedge clock);
    io_valid = 1'b1;
    io_insn  = {r[31:15], ch, r[11:7], op};
    io_rs1   = rs1;
    io_rs2   = rs2;
    for (int i = 0; i < 40; i++) begin
      if (io_ready) begin
        @(posedge clock);
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    #1;
    io_valid = 1'b0;
    if (!ok) begin
      compared++; mismatched++;
      $display("FAIL accept_timeout op=%h ch=%0d io_ready stayed %b, required 1", op, ch, io_ready);
    end else begin
      model_cmd(op, int'(ch), rs1, rs2);
    end
  endtask

  // READ, then check pulse and value against the model
  task automatic read_check(input logic [2:0] ch, input string name);
    bit exp_pulse;
    exp_pulse = (int'(ch) < CHANNELS);
    send(OP_READ, ch, $urandom, $urandom);
    compared += 2;
    if (io_rd_valid !== exp_pulse) begin
      mismatched++;
      $display("FAIL %s rd_valid got %b, required %b", name, io_rd_valid, exp_pulse);
    end
    if (io_rd !== last_rd) begin
      mismatched++;
      $display("FAIL %s rd got %h, required %h", name, io_rd, last_rd);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; io_valid = 1'b0; io_insn = '0; io_rs1 = '0; io_rs2 = '0;
    model_clear();
    #12;
    compared += 3;
    if (io_ready !== 1'b1)    begin mismatched++; $display("FAIL reset_ready got %b, required 1", io_ready); end
    if (io_rd !== '0)         begin mismatched++; $display("FAIL reset_rd got %h, required 0", io_rd); end
    if (io_rd_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rd_valid got %b, required 0", io_rd_valid); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int c [5] = '{5, 99, 47, 41, 25};
    int x [5] = '{90, 64, 93, 1, 97};
    int e [5] = '{450, 9230, 11031, 15910, 9829};
    for (int i = 0; i < 5; i++) send(OP_SETCOEF, 3'd0, c[i], i);
    for (int i = 0; i < 5; i++) begin
      send(OP_PUSH, 3'd0, x[i], 0);
      read_check(3'd0, "basic_model");
      compared++;
      if (io_rd !== e[i]) begin
        mismatched++;
        $display("FAIL basic_const[%0d] got %0d, required %0d", i, io_rd, e[i]);
      end
    end
  endtask

  task automatic test_handshake();
    int  low_cnt;
    bit  early_pulse, got;
    low_cnt = 0; early_pulse = 1'b0; got = 1'b0;
    send(OP_PUSH, 3'd0, 32'd55, 0);
    @(negedge clock);
    io_valid = 1'b1;
    io_insn  = {17'd0, 3'd0, 5'd0, OP_READ};
    for (int i = 0; i < 30; i++) begin
      if (io_ready) begin got = 1'b1; break; end
      low_cnt++;
      if (io_rd_valid) early_pulse = 1'b1;
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    io_valid = 1'b0;
    model_cmd(OP_READ, 0, '0, '0);
    compared += 4;
    if (!got || low_cnt != TAPS+1) begin
      mismatched++;
      $display("FAIL hs_busy_cycles got %0d, required %0d", low_cnt, TAPS+1);
    end
    if (early_pulse) begin mismatched++; $display("FAIL hs_early_pulse got 1, required 0"); end
    if (io_rd_valid !== 1'b1) begin mismatched++; $display("FAIL hs_rd_valid got %b, required 1", io_rd_valid); end
    if (io_rd !== last_rd) begin mismatched++; $display("FAIL hs_rd got %h, required %h", io_rd, last_rd); end
  endtask

  task automatic test_channels();
    logic [XLEN-1:0] r0;
    r0 = rm[0];
    send(OP_SETCOEF, 3'd1, -32'sd3, 0);
    send(OP_PUSH, 3'd1, 32'd7, 0);
    read_check(3'd1, "chan1_model");
    compared++;
    if (io_rd !== 32'hFFFFFFEB) begin mismatched++; $display("FAIL chan1_const got %h, required ffffffeb", io_rd); end
    read_check(3'd0, "chan0_model");
    compared++;
    if (io_rd !== r0) begin mismatched++; $display("FAIL chan0_untouched got %h, required %h", io_rd, r0); end
    send(OP_SETCOEF, 3'd5, 32'd1000, 0);
    send(OP_PUSH, 3'd5, 32'd1000, 0);
    send(OP_CONFIG, 3'd5, 32'h3FF, 0);
    read_check(3'd5, "chan5_ignored");
    read_check(3'd0, "chan0_after5");
    read_check(3'd1, "chan1_after5");
  endtask

  task automatic test_back_to_back();
    read_check(3'd1, "b2b_first");
    read_check(3'd0, "b2b_second");
    @(posedge clock);
    #1;
    compared++;
    if (io_rd_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_pulse_end got %b, required 0", io_rd_valid); end
  endtask

  task automatic test_shift_sat();
    send(OP_CONFIG, 3'd0, 32'h202, 0);
    send(OP_PUSH, 3'd0, 32'd90, 0);
    read_check(3'd0, "shift_model");
    compared++;
    if (io_rd !== 32'd112) begin mismatched++; $display("FAIL shift_const got %0d, required 112", io_rd); end
    send(OP_SETCOEF, 3'd0, 32'h7FFFFFFF, 0);
    send(OP_CONFIG, 3'd0, 32'h300, 0);
    send(OP_PUSH, 3'd0, 32'd2, 0);
    read_check(3'd0, "sat_hi_model");
    compared++;
    if (io_rd !== 32'h7FFFFFFF) begin mismatched++; $display("FAIL sat_hi_const got %h, required 7fffffff", io_rd); end
    send(OP_CONFIG, 3'd0, 32'h200, 0);
    send(OP_PUSH, 3'd0, 32'd2, 0);
    read_check(3'd0, "trunc_model");
    compared++;
    if (io_rd !== 32'hFFFFFFFE) begin mismatched++; $display("FAIL trunc_const got %h, required fffffffe", io_rd); end
    send(OP_SETCOEF, 3'd0, 32'h80000000, 0);
    send(OP_CONFIG, 3'd0, 32'h300, 0);
    send(OP_PUSH, 3'd0, 32'd2, 0);
    read_check(3'd0, "sat_lo_model");
    compared++;
    if (io_rd !== 32'h80000000) begin mismatched++; $display("FAIL sat_lo_const got %h, required 80000000", io_rd); end
  endtask

  task automatic test_clear_reset();
    send(OP_SETCOEF, 3'd0, 32'd5, 0);
    send(OP_CONFIG, 3'd0, 32'h200, 0);
    read_check(3'd0, "clear_model");
    compared++;
    if (io_rd !== '0) begin mismatched++; $display("FAIL clear_const got %h, required 0", io_rd); end
    send(OP_PUSH, 3'd0, 32'd10, 0);
    read_check(3'd0, "post_clear_model");
    compared++;
    if (io_rd !== 32'd50) begin mismatched++; $display("FAIL post_clear_const got %0d, required 50", io_rd); end
    send(OP_PUSH, 3'd0, 32'd3, 0);
    repeat (3) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    compared += 2;
    if (io_ready !== 1'b1) begin mismatched++; $display("FAIL midmac_ready got %b, required 1", io_ready); end
    if (io_rd !== '0)      begin mismatched++; $display("FAIL midmac_rd got %h, required 0", io_rd); end
    model_clear();
    @(negedge clock);
    reset = 1'b0;
    read_check(3'd0, "after_reset");
  endtask

  task automatic test_ignored();
    send(OP_SETCOEF, 3'd0, 32'd7, 0);
    send(OP_SETCOEF, 3'd0, 32'd3, 1);
    send(OP_SETCOEF, 3'd0, 32'd1234, 8);
    send(OP_UNK, 3'd0, 32'hFFFFFFFF, 0);
    send(OP_PUSH, 3'd0, 32'd11, 0);
    send(OP_UNK, 3'd1, 32'h3FF, 3);
    send(OP_PUSH, 3'd0, 32'd4, 0);
    read_check(3'd0, "ignored_model");
    compared++;
    if (io_rd !== 32'd61) begin mismatched++; $display("FAIL ignored_const got %0d, required 61", io_rd); end
  endtask

  task automatic test_random();
    logic [6:0]      ops [5] = '{OP_SETCOEF, OP_PUSH, OP_READ, OP_CONFIG, OP_UNK};
    logic [6:0]      op;
    logic [2:0]      ch;
    logic [XLEN-1:0] rs1, rs2;
    for (int n = 0; n < 300; n++) begin
      op  = ops[$urandom_range(0, 4)];
      ch  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      rs1 = $urandom;
      rs2 = $urandom_range(0, 9);
      if (op == OP_CONFIG) rs1 = {22'd0, ($urandom_range(0, 5) == 0), 1'($urandom), 2'd0, 6'($urandom_range(0, 40))};
      if (op == OP_READ) read_check(ch, "random_read");
      else               send(op, ch, rs1, rs2);
    end
    read_check(3'd0, "random_final0");
    read_check(3'd1, "random_final1");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_handshake();
    test_channels();
    test_back_to_back();
    test_shift_sat();
    test_clear_reset();
    test_ignored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/scie_fir_mac_seq.md
Name: scie_fir_mac_seq

Overview:
- Parametrised successor to the fixed 5-tap pipelined SCIE FIR accelerator.
- Holds CHANNELS independent FIR filters. Each channel has TAPS signed coefficients and its own delay line.
- A single shared multiplier-accumulator processes one tap per cycle. A ready/valid handshake stalls the core while a filter update is in progress.
- Adds per-channel arithmetic shift, optional saturation, and a clear operation.
- Sits on the SCIE custom-instruction interface: opcode, rs1 and rs2 in; rd out.

Parameters:
- XLEN, 32, width of rs1/rs2/rd, samples and coefficients (signed).
- TAPS, 8, taps per channel (2..32).
- CHANNELS, 2, independent filters (1..8).
- ACC_W, 2*XLEN+5, accumulator width (signed).

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-high reset
- io_valid  in  1  command valid
- io_ready  out  1  command accepted when io_valid && io_ready
- io_insn  in  32  instruction; [6:0] opcode, [14:12] channel
- io_rs1  in  XLEN  operand 1
- io_rs2  in  XLEN  operand 2
- io_rd  out  XLEN  read result, held until next READ
- io_rd_valid  out  1  one-cycle pulse when io_rd is updated

Behaviour:
- Reset (async): all coefficients, delay lines, results, shift and sat registers = 0; FSM = IDLE; io_ready=1; io_rd=0; io_rd_valid=0.
- Channel ch = insn[14:12]. Commands with ch >= CHANNELS are accepted and ignored.
- Unknown opcodes are accepted and ignored.
- Opcodes (accepted only in IDLE):
  - 0x0B SETCOEF: coef[ch][rs2] <= rs1. rs2 >= TAPS: ignored. Single cycle.
  - 0x2B PUSH: shift delay line (x[0] <= rs1, x[k] <= x[k-1]); FSM -> MAC.
  - 0x5B READ: io_rd <= result[ch] on the next edge; io_rd_valid=1 for that cycle. Single cycle, so back-to-back READs are allowed.
  - 0x7B CONFIG: shift[ch] <= min(rs1[5:0], ACC_W-1); sat[ch] <= rs1[8]. If rs1[9]=1, clear delay line and result[ch] (coefficients kept).
- FSM:
  - IDLE: io_ready=1.
  - MAC: io_ready=0. Counter k runs 0..TAPS-1; acc += coef[ch][k]*x[k] (full signed product, sign-extended to ACC_W). acc is cleared on PUSH acceptance. After k=TAPS-1 -> WB.
  - WB: io_ready=0. t = acc >>> shift[ch] (arithmetic).
    - sat=1: clamp t to [-2^(XLEN-1), 2^(XLEN-1)-1].
    - sat=0: truncate t to its low XLEN bits.
    - Write result[ch]; -> IDLE.
- Latency: PUSH accepted at edge t. io_ready is low for exactly TAPS+1 cycles and high again after edge t+TAPS+1. A READ accepted at that point returns the new value.
- io_valid while io_ready=0: not accepted, no side effect. The requester must hold the command.
- Reset asserted mid-MAC: the computation is abandoned and all state is cleared immediately.
- Accumulator cannot overflow for ACC_W >= 2*XLEN+ceil(log2(TAPS)).

Test Plan:
- Setup for scenarios 1–2: TAPS=8, ch0 coefficients 5,99,47,41,25 at taps 0..4, taps 5..7 = 0.
- 1. Basic filter: PUSH 90,64,93,1,97, each followed by READ. Required io_rd = 450, 9230, 11031, 15910, 9829.
- 2. Handshake: hold io_valid with READ during the PUSH computation. Required: io_ready=0 for 9 cycles; READ accepted on the 10th cycle and returns the new result; no io_rd_valid pulse earlier.
- 3. Channel isolation: ch1 coef0=-3, PUSH 7 on ch1, READ ch1 -> 0xFFFFFFEB. ch0 results unchanged. Command with ch=5 -> no state change.
- 4. Shift and saturation:
  - ch0 CONFIG shift=2, PUSH 90 (zeroed line, coef0=5) -> 112.
  - coef0=0x7FFFFFFF, PUSH 2: sat=1 -> 0x7FFFFFFF; sat=0 -> 0xFFFFFFFE.
- 5. Clear and reset:
  - CONFIG rs1[9]=1, then READ -> 0; next PUSH 10 -> 50 (coefficients retained).
  - Assert reset mid-MAC -> io_ready=1 and io_rd=0 immediately; READ afterwards returns 0.
- 6. Ignored commands: SETCOEF with rs2=8 and unknown opcode 0x13 -> accepted, no state change; following PUSH/READ results match the model.
